// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int REG_ID_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_REDIR   = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-detect inputs and stage-latch control outputs.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ID_W = 5,
    parameter int CNT_W    = 16
);
    logic                rf_valid;
    logic [REG_ID_W-1:0] rf_rd0_id;
    logic                rf_rd0_used;
    logic [REG_ID_W-1:0] rf_rd1_id;
    logic                rf_rd1_used;
    logic [REG_ID_W-1:0] ex_wr_id;
    logic                ex_wr_en;
    logic                ex_is_load;
    logic                mem_busy;
    logic                br_taken;
    logic                perf_clr;

    logic                if_stall, rf_stall, ex_stall;
    logic                if_flush, rf_flush, ex_flush;
    logic [1:0]          state_out;
    logic [CNT_W-1:0]    stall_cycles;

    modport master (
        output rf_valid, rf_rd0_id, rf_rd0_used, rf_rd1_id, rf_rd1_used,
               ex_wr_id, ex_wr_en, ex_is_load, mem_busy, br_taken, perf_clr,
        input  if_stall, rf_stall, ex_stall, if_flush, rf_flush, ex_flush,
               state_out, stall_cycles
    );

    modport slave (
        input  rf_valid, rf_rd0_id, rf_rd0_used, rf_rd1_id, rf_rd1_used,
               ex_wr_id, ex_wr_en, ex_is_load, mem_busy, br_taken, perf_clr,
        output if_stall, rf_stall, ex_stall, if_flush, rf_flush, ex_flush,
               state_out, stall_cycles
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the RF sources and the EX load destination.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ID_W = REG_ID_W_DEF
) (
    input  logic                rf_valid_i,
    input  logic [REG_ID_W-1:0] rf_rd0_id_i,
    input  logic                rf_rd0_used_i,
    input  logic [REG_ID_W-1:0] rf_rd1_id_i,
    input  logic                rf_rd1_used_i,
    input  logic [REG_ID_W-1:0] ex_wr_id_i,
    input  logic                ex_wr_en_i,
    input  logic                ex_is_load_i,
    output logic                hazard_o
);
    logic ex_ld_wr;
    logic src_match;

    // Register 0 is "no register" and can never carry a dependency.
    assign ex_ld_wr  = ex_is_load_i & ex_wr_en_i & (ex_wr_id_i != '0);
    assign src_match = (rf_rd0_used_i & (rf_rd0_id_i == ex_wr_id_i)) |
                       (rf_rd1_used_i & (rf_rd1_id_i == ex_wr_id_i));
    assign hazard_o  = rf_valid_i & ex_ld_wr & src_match;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/RF/EX latches plus a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ID_W     = REG_ID_W_DEF,
    parameter int LDUSE_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int MAXC   = (LDUSE_CYCLES > FLUSH_CYCLES) ? LDUSE_CYCLES : FLUSH_CYCLES;
    localparam int CNTR_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
    localparam logic [CNTR_W-1:0] LDUSE_INIT = CNTR_W'(LDUSE_CYCLES - 1);
    localparam logic [CNTR_W-1:0] FLUSH_INIT = CNTR_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNTR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic hazard;
    logic ifs_c, rfs_c, exs_c, iff_c, rff_c, exf_c;
    logic eval_run;
    logic any_stall;

    load_use_detect #(.REG_ID_W(REG_ID_W)) u_lud (
        .rf_valid_i   (bus.rf_valid),
        .rf_rd0_id_i  (bus.rf_rd0_id),
        .rf_rd0_used_i(bus.rf_rd0_used),
        .rf_rd1_id_i  (bus.rf_rd1_id),
        .rf_rd1_used_i(bus.rf_rd1_used),
        .ex_wr_id_i   (bus.ex_wr_id),
        .ex_wr_en_i   (bus.ex_wr_en),
        .ex_is_load_i (bus.ex_is_load),
        .hazard_o     (hazard)
    );

    // Next state and same-cycle latch controls; mem_busy > br_taken > hazard.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ifs_c    = 1'b0;
        rfs_c    = 1'b0;
        exs_c    = 1'b0;
        iff_c    = 1'b0;
        rff_c    = 1'b0;
        exf_c    = 1'b0;
        eval_run = 1'b0;

        if (bus.mem_busy) begin
            // Memory hold freezes everything; RUN moves into MEMWAIT, others stay.
            {ifs_c, rfs_c, exs_c} = 3'b111;
            if (state_q == ST_RUN) state_d = ST_MEMWAIT;
        end else begin
            case (state_q)
                ST_RUN, ST_MEMWAIT: eval_run = 1'b1;
                ST_LDUSE: begin
                    if (bus.br_taken) begin
                        eval_run = 1'b1;
                    end else begin
                        {ifs_c, rfs_c, exf_c} = 3'b111;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_d == '0) state_d = ST_RUN;
                    end
                end
                ST_REDIR: begin
                    // RF holds wrong-path work, so hazards and new branches are ignored.
                    {iff_c, rff_c} = 2'b11;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_d == '0) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (eval_run) begin
            state_d = ST_RUN;
            if (bus.br_taken) begin
                {iff_c, rff_c} = 2'b11;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_REDIR;
                    cnt_d   = FLUSH_INIT;
                end
            end else if (hazard) begin
                {ifs_c, rfs_c, exf_c} = 3'b111;
                if (LDUSE_CYCLES > 1) begin
                    state_d = ST_LDUSE;
                    cnt_d   = LDUSE_INIT;
                end
            end
        end
    end

    // Controls drop to 0 the moment reset asserts, without waiting for a clock.
    assign bus.if_stall = ifs_c & RST;
    assign bus.rf_stall = rfs_c & RST;
    assign bus.ex_stall = exs_c & RST;
    assign bus.if_flush = iff_c & RST;
    assign bus.rf_flush = rff_c & RST;
    assign bus.ex_flush = exf_c & RST;

    assign any_stall = ifs_c | rfs_c | exs_c;

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.perf_clr)
            stall_cycles_d = '0;
        else if (any_stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // State, bubble counter and perf counter registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.state_out    = state_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (LDUSE_CYCLES=1, FLUSH_CYCLES=2, CNT_W=16).
module tb_pipe_hazard_ctrl;
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_MEM  = 6'b111000;  // {ifs,rfs,exs,iff,rff,exf}
    localparam logic [5:0] O_LDU  = 6'b110001;
    localparam logic [5:0] O_FLU  = 6'b000110;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   ntot  = 0;
    int   npass = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.REG_ID_W(5), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .REG_ID_W    (5),
        .LDUSE_CYCLES(1),
        .FLUSH_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    function automatic logic [5:0] outs();
        return {bus.if_stall, bus.rf_stall, bus.ex_stall,
                bus.if_flush, bus.rf_flush, bus.ex_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.rf_valid = 0; bus.rf_rd0_id = 0; bus.rf_rd0_used = 0;
        bus.rf_rd1_id = 0; bus.rf_rd1_used = 0; bus.ex_wr_id = 0;
        bus.ex_wr_en = 0; bus.ex_is_load = 0; bus.mem_busy = 0;
        bus.br_taken = 0; bus.perf_clr = 0;
    endtask

    task automatic set_hazard(input logic [4:0] rd0, input logic used0,
                              input logic [4:0] wr, input logic ld);
        bus.rf_valid = 1; bus.rf_rd0_id = rd0; bus.rf_rd0_used = used0;
        bus.ex_wr_id = wr; bus.ex_wr_en = 1; bus.ex_is_load = ld;
    endtask

    initial begin
        idle();
        // Reset state
        repeat (2) tick();
        chk("rst_outs", 32'(outs()), 32'(O_NONE));
        chk("rst_state", 32'(bus.state_out), 0);
        chk("rst_cnt", 32'(bus.stall_cycles), 0);
        RST = 1'b1;
        tick();

        // 1. load-use on rd0, one bubble
        set_hazard(5'd3, 1'b1, 5'd3, 1'b1); #2;
        chk("lu_outs", 32'(outs()), 32'(O_LDU));
        chk("lu_state", 32'(bus.state_out), 0);
        tick();
        idle(); #2;
        chk("lu_after", 32'(outs()), 32'(O_NONE));
        chk("lu_state1", 32'(bus.state_out), 0);
        chk("lu_cnt", 32'(bus.stall_cycles), 1);
        tick();

        // 2. non-hazards, then a hazard on rd1
        set_hazard(5'd0, 1'b1, 5'd0, 1'b1); #2;
        chk("nh_zero", 32'(outs()), 32'(O_NONE)); tick();
        set_hazard(5'd3, 1'b0, 5'd3, 1'b1); #2;
        chk("nh_unused", 32'(outs()), 32'(O_NONE)); tick();
        set_hazard(5'd3, 1'b1, 5'd3, 1'b0); #2;
        chk("nh_noload", 32'(outs()), 32'(O_NONE)); tick();
        idle();
        bus.rf_valid = 1; bus.rf_rd1_id = 5'd7; bus.rf_rd1_used = 1;
        bus.ex_wr_id = 5'd7; bus.ex_wr_en = 1; bus.ex_is_load = 1; #2;
        chk("lu_rd1", 32'(outs()), 32'(O_LDU)); tick();
        idle(); #2;
        chk("cnt_two", 32'(bus.stall_cycles), 2);
        bus.perf_clr = 1; tick();
        bus.perf_clr = 0; #2;
        chk("perf_clr", 32'(bus.stall_cycles), 0);
        tick();

        // 3. mem_busy for 4 cycles
        bus.mem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("mb_outs", 32'(outs()), 32'(O_MEM));
            chk("mb_state", 32'(bus.state_out), (i == 0) ? 0 : 2);
            tick();
        end
        bus.mem_busy = 0; #2;
        chk("mb_drop_outs", 32'(outs()), 32'(O_NONE));
        chk("mb_drop_state", 32'(bus.state_out), 2);
        chk("mb_cnt", 32'(bus.stall_cycles), 4);
        tick();
        chk("mb_run", 32'(bus.state_out), 0);
        bus.perf_clr = 1; tick();
        bus.perf_clr = 0;

        // 4. taken branch beats a hazard, two flush cycles
        set_hazard(5'd3, 1'b1, 5'd3, 1'b1);
        bus.br_taken = 1; #2;
        chk("br_outs0", 32'(outs()), 32'(O_FLU));
        tick();
        chk("br_state1", 32'(bus.state_out), 3);
        chk("br_outs1", 32'(outs()), 32'(O_FLU));
        tick();
        idle(); #2;
        chk("br_done", 32'(outs()), 32'(O_NONE));
        chk("br_state2", 32'(bus.state_out), 0);
        chk("br_nostall", 32'(bus.stall_cycles), 0);
        tick();

        // 5. mem_busy + br_taken for 3 cycles, flush when busy drops
        bus.mem_busy = 1; bus.br_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mbbr_outs", 32'(outs()), 32'(O_MEM));
            tick();
        end
        bus.mem_busy = 0; #2;
        chk("mbbr_flush", 32'(outs()), 32'(O_FLU));
        chk("mbbr_state", 32'(bus.state_out), 2);
        tick();
        bus.br_taken = 0; #2;
        chk("mbbr_redir", 32'(bus.state_out), 3);
        chk("mbbr_flush2", 32'(outs()), 32'(O_FLU));
        tick();
        chk("mbbr_run", 32'(bus.state_out), 0);
        chk("mbbr_cnt", 32'(bus.stall_cycles), 3);

        // 6. reset mid-REDIR
        bus.br_taken = 1; tick();
        bus.br_taken = 0; #2;
        chk("rr_state", 32'(bus.state_out), 3);
        chk("rr_outs", 32'(outs()), 32'(O_FLU));
        RST = 1'b0; #1;
        chk("rr_async_outs", 32'(outs()), 32'(O_NONE));
        chk("rr_async_state", 32'(bus.state_out), 0);
        chk("rr_async_cnt", 32'(bus.stall_cycles), 0);
        tick();
        RST = 1'b1; tick();
        chk("rr_run", 32'(bus.state_out), 0);

        // Saturation under continuous mem_busy
        bus.mem_busy = 1;
        repeat (65535) tick();
        chk("sat_full", 32'(bus.stall_cycles), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);
        bus.perf_clr = 1; tick();
        chk("sat_clr", 32'(bus.stall_cycles), 0);
        idle(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
